// File: rtl/pipe_regfile_sb_pkg.sv
// Shared constants for the ID/WB register file, scoreboard and the
// hazard/forwarding units that sit next to it.
package pipe_regfile_sb_pkg;
   localparam int DW_DEF   = 32;   // data width
   localparam int AW_DEF   = 5;    // register address width
   localparam int PW_DEF   = 2;    // pending-writer counter width
   localparam int REG_ZERO = 0;    // architectural zero register number
endpackage

// File: rtl/pipe_sb_cnt.sv
// One pending-write counter: counts issued-but-not-written-back producers
// of a single register. Saturates at both ends, never wraps.
module pipe_sb_cnt
   import pipe_regfile_sb_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          inc,
   input  logic          dec,
   input  logic          clr,
   output logic [PW-1:0] cnt
);
   localparam logic [PW-1:0] CMAX = '1;

   // clr (flush) dominates; inc+dec together cancel out
   always_ff @(posedge clk or negedge clrn)
      if (!clrn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !dec && cnt != CMAX)
         cnt <= cnt + 1'b1;
      else if (dec && !inc && cnt != '0)
         cnt <= cnt - 1'b1;
endmodule

// File: rtl/pipe_regfile_sb.sv
// Register file with write-through bypass on both read ports plus a
// per-register pending-writer scoreboard, so ID can stall on RAW hazards
// by itself.
module pipe_regfile_sb
   import pipe_regfile_sb_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int PW       = PW_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic [AW-1:0] rna,
   input  logic [AW-1:0] rnb,
   output logic [DW-1:0] qa,
   output logic [DW-1:0] qb,
   input  logic          we,
   input  logic [AW-1:0] wn,
   input  logic [DW-1:0] d,
   input  logic          iss,
   input  logic [AW-1:0] iss_wn,
   input  logic          flush,
   output logic          busy_a,
   output logic          busy_b,
   output logic          iss_full,
   output logic          sb_err
);
   localparam int              NREG = 1 << AW;
   localparam logic [PW-1:0]   CMAX = '1;
   localparam logic [PW-1:0]   CONE = PW'(1);
   localparam logic [AW-1:0]   R0   = AW'(REG_ZERO);
   localparam bit              ZR   = (ZERO_REG != 0);

   logic [NREG-1:0][DW-1:0] rf;
   logic [NREG-1:0][PW-1:0] cnt;
   logic                    wr_ok;

   // writes to the hardwired zero register are discarded
   assign wr_ok = we && !(ZR && wn == R0);

   // register array; async clear so reset is visible on qa/qb immediately
   always_ff @(posedge clk or negedge clrn)
      if (!clrn)
         rf <= '0;
      else if (wr_ok)
         rf[wn] <= d;

   // read port A: zero reg, then WB bypass, then array
   always_comb begin
      qa = rf[rna];
      if (we && wn == rna) qa = d;
      if (ZR && rna == R0) qa = '0;
   end

   // read port B: same priority as port A
   always_comb begin
      qb = rf[rnb];
      if (we && wn == rnb) qb = d;
      if (ZR && rnb == R0) qb = '0;
   end

   // one pending counter per register; zero register has none
   for (genvar r = 0; r < NREG; r++) begin : g_cnt
      if (ZR && r == REG_ZERO) begin : g_tie
         assign cnt[r] = '0;
      end else begin : g_inst
         logic inc, dec;
         // a dropped issue (counter full) must not disturb the count
         assign inc = iss && iss_wn == AW'(r) && !iss_full;
         assign dec = we && wn == AW'(r) && cnt[r] != '0;
         pipe_sb_cnt #(.PW(PW)) u_cnt (
            .clk  (clk),
            .clrn (clrn),
            .inc  (inc),
            .dec  (dec),
            .clr  (flush),
            .cnt  (cnt[r])
         );
      end
   end

   assign iss_full = (cnt[iss_wn] == CMAX);

   // the last outstanding writer landing this cycle is bypassed, so no stall
   assign busy_a = (cnt[rna] != '0) && !(we && wn == rna && cnt[rna] == CONE);
   assign busy_b = (cnt[rnb] != '0) && !(we && wn == rnb && cnt[rnb] == CONE);

   // sticky: a writeback arrived that nobody had issued
   always_ff @(posedge clk or negedge clrn)
      if (!clrn)
         sb_err <= 1'b0;
      else if (wr_ok && cnt[wn] == '0 && !flush)
         sb_err <= 1'b1;
endmodule

// File: tb/tb_pipe_regfile_sb.sv
// Bench for pipe_regfile_sb: directed scenarios plus a random run, all
// checked against an array/integer model of the register file and scoreboard.
module tb_pipe_regfile_sb;
   localparam int DW = 32, AW = 5, PW = 2, ZR = 1;
   localparam int NREG = 1 << AW;
   localparam int CMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          clrn;
   logic [AW-1:0] rna, rnb, wn, iss_wn;
   logic [DW-1:0] qa, qb, d;
   logic          we, iss, flush;
   logic          busy_a, busy_b, iss_full, sb_err;

   int checks = 0, failures = 0;

   logic [DW-1:0] mreg [NREG];
   int            mcnt [NREG];
   bit            merr;

   always #5 clk = ~clk;

   pipe_regfile_sb #(.DW(DW), .AW(AW), .PW(PW), .ZERO_REG(ZR)) dut (
      .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
      .we(we), .wn(wn), .d(d), .iss(iss), .iss_wn(iss_wn), .flush(flush),
      .busy_a(busy_a), .busy_b(busy_b), .iss_full(iss_full), .sb_err(sb_err)
   );

   // ---- reference model --------------------------------------------------
   function automatic logic [DW-1:0] exp_q(input logic [AW-1:0] a);
      if (ZR != 0 && a == 0) return '0;
      if (we && wn == a) return d;
      return mreg[a];
   endfunction

   function automatic bit exp_busy(input logic [AW-1:0] a);
      return mcnt[a] != 0 && !(we && wn == a && mcnt[a] == 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin mreg[i] = '0; mcnt[i] = 0; end
      merr = 0;
   endtask

   // apply current inputs to the model, then advance one clock
   task automatic tick();
      bit zw, full, incr, decr;
      zw   = (ZR != 0 && wn == 0);
      full = (mcnt[iss_wn] == CMAX);
      incr = iss && !full && !(ZR != 0 && iss_wn == 0) && !flush;
      decr = we && mcnt[wn] != 0;
      if (we && !zw && mcnt[wn] == 0 && !flush) merr = 1;
      if (we && !zw) mreg[wn] = d;
      if (flush) begin
         for (int i = 0; i < NREG; i++) mcnt[i] = 0;
      end else begin
         if (incr) mcnt[iss_wn] = mcnt[iss_wn] + 1;
         if (decr) mcnt[wn] = mcnt[wn] - 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 0; iss = 0; flush = 0;
   endtask

   // async reset pulse mid-cycle, then realign to the drive slot
   task automatic pulse_reset();
      idle();
      #1 clrn = 0;
      #1 model_reset();
      clrn = 1;
      @(posedge clk);
      #1;
   endtask

   // ---- scenarios --------------------------------------------------------
   task automatic test_reset();
      idle(); rna = 5'd12; rnb = 5'd5; #2;
      checks++; if (qa !== '0) begin failures++; $display("FAIL rst_qa got=%h exp=0", qa); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL rst_sberr got=%b exp=0", sb_err); end
      checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_b); end
      we = 1; wn = 5; d = 32'hDEADBEEF; iss = 1; iss_wn = 5;
      tick();
      idle(); rna = 5; #2;
      checks++; if (qa !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_wr5 got=%h exp=deadbeef", qa); end
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL rst_busy5 got=%b exp=1", busy_a); end
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL rst_err_set got=%b exp=1", sb_err); end
      clrn = 0; #1;
      checks++; if (qa !== '0) begin failures++; $display("FAIL rst_async_qa got=%h exp=0", qa); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy_a); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL rst_async_err got=%b exp=0", sb_err); end
      model_reset();
      clrn = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_bypass();
      idle(); rna = 7; rnb = 7; we = 1; wn = 7; d = 32'h12345678; #2;
      checks++; if (qa !== 32'h12345678) begin failures++; $display("FAIL byp_qa got=%h exp=12345678", qa); end
      checks++; if (qb !== 32'h12345678) begin failures++; $display("FAIL byp_qb got=%h exp=12345678", qb); end
      tick();
      idle(); #2;
      checks++; if (qa !== 32'h12345678) begin failures++; $display("FAIL byp_stored got=%h exp=12345678", qa); end
   endtask

   task automatic test_raw();
      pulse_reset();
      idle(); iss = 1; iss_wn = 3; rna = 3; rnb = 3;
      tick();
      idle(); #2;
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL raw_busy1 got=%b exp=1", busy_a); end
      iss = 1; iss_wn = 3;
      tick();
      idle(); we = 1; wn = 3; d = 32'hAAAA0001; #2;
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL raw_wb1_busy got=%b exp=1", busy_a); end
      tick();
      idle(); we = 1; wn = 3; d = 32'hBBBB0002; #2;
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL raw_wb2_busy got=%b exp=0", busy_a); end
      checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL raw_wb2_busyb got=%b exp=0", busy_b); end
      checks++; if (qa !== 32'hBBBB0002) begin failures++; $display("FAIL raw_wb2_qa got=%h exp=bbbb0002", qa); end
      tick();
      idle(); #2;
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL raw_done_busy got=%b exp=0", busy_a); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL raw_sberr got=%b exp=0", sb_err); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         idle(); iss = 1; iss_wn = 9; tick();
      end
      idle(); iss_wn = 9; rna = 9; #2;
      checks++; if (iss_full !== 1'b1) begin failures++; $display("FAIL sat_full3 got=%b exp=1", iss_full); end
      iss = 1; tick();
      idle(); #2;
      checks++; if (iss_full !== 1'b1) begin failures++; $display("FAIL sat_full4 got=%b exp=1", iss_full); end
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL sat_busy4 got=%b exp=1", busy_a); end
      we = 1; wn = 9; d = 32'h9; tick();
      idle(); #2;
      checks++; if (iss_full !== 1'b0) begin failures++; $display("FAIL sat_dec got=%b exp=0", iss_full); end
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL sat_nowrap got=%b exp=1", busy_a); end
      iss = 1; we = 1; wn = 9; d = 32'h99; tick();
      idle(); #2;
      checks++; if (iss_full !== 1'b0) begin failures++; $display("FAIL sat_incdec got=%b exp=0", iss_full); end
      iss = 1; tick();
      idle(); #2;
      checks++; if (iss_full !== 1'b1) begin failures++; $display("FAIL sat_refill got=%b exp=1", iss_full); end
   endtask

   task automatic test_flush_err();
      pulse_reset();
      idle(); iss = 1; iss_wn = 4; tick();
      idle(); iss = 1; iss_wn = 6; tick();
      idle(); rna = 4; rnb = 6; #2;
      checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin failures++; $display("FAIL fl_pre got=%b%b exp=11", busy_a, busy_b); end
      flush = 1; iss = 1; iss_wn = 4; tick();
      idle(); #2;
      checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL fl_post got=%b%b exp=00", busy_a, busy_b); end
      flush = 1; we = 1; wn = 6; d = 32'h0000600D; tick();
      idle(); #2;
      checks++; if (qb !== 32'h0000600D) begin failures++; $display("FAIL fl_write got=%h exp=0000600d", qb); end
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL fl_noerr got=%b exp=0", sb_err); end
      we = 1; wn = 4; d = 32'hCAFEF00D; tick();
      idle(); #2;
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", sb_err); end
      checks++; if (qa !== 32'hCAFEF00D) begin failures++; $display("FAIL err_write got=%h exp=cafef00d", qa); end
      tick(); tick(); #2;
      checks++; if (sb_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", sb_err); end
      pulse_reset(); #2;
      checks++; if (sb_err !== 1'b0) begin failures++; $display("FAIL err_clr got=%b exp=0", sb_err); end
   endtask

   task automatic test_zero_reg();
      idle(); rna = 0; we = 1; wn = 0; d = 32'hFFFFFFFF; iss = 1; iss_wn = 0; #2;
      checks++; if (qa !== '0) begin failures++; $display("FAIL z_qa_byp got=%h exp=0", qa); end
      checks++; if (iss_full !== 1'b0) begin failures++; $display("FAIL z_full got=%b exp=0", iss_full); end
      tick();
      idle(); #2;
      checks++; if (qa !== '0) begin failures++; $display("FAIL z_qa got=%h exp=0", qa); end
      checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL z_busy got=%b exp=0", busy_a); end
      checks++; if (sb_err !== merr) begin failures++; $display("FAIL z_sberr got=%b exp=%b", sb_err, merr); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if (n % 150 == 149) pulse_reset();
         rna    = AW'($urandom_range(0, 7));
         rnb    = AW'($urandom_range(0, 7));
         wn     = AW'($urandom_range(0, 7));
         iss_wn = AW'($urandom_range(0, 7));
         d      = $urandom;
         we     = ($urandom_range(0, 9) < 4);
         iss    = ($urandom_range(0, 9) < 5);
         flush  = ($urandom_range(0, 49) == 0);
         #2;
         checks++; if (qa !== exp_q(rna)) begin failures++; $display("FAIL rnd_qa n=%0d got=%h exp=%h", n, qa, exp_q(rna)); end
         checks++; if (qb !== exp_q(rnb)) begin failures++; $display("FAIL rnd_qb n=%0d got=%h exp=%h", n, qb, exp_q(rnb)); end
         checks++; if (busy_a !== exp_busy(rna)) begin failures++; $display("FAIL rnd_busy_a n=%0d got=%b exp=%b", n, busy_a, exp_busy(rna)); end
         checks++; if (busy_b !== exp_busy(rnb)) begin failures++; $display("FAIL rnd_busy_b n=%0d got=%b exp=%b", n, busy_b, exp_busy(rnb)); end
         checks++; if (iss_full !== (mcnt[iss_wn] == CMAX)) begin failures++; $display("FAIL rnd_full n=%0d got=%b cnt=%0d", n, iss_full, mcnt[iss_wn]); end
         checks++; if (sb_err !== merr) begin failures++; $display("FAIL rnd_sberr n=%0d got=%b exp=%b", n, sb_err, merr); end
         tick();
      end
   endtask

   initial begin
      clrn = 0; idle(); rna = 0; rnb = 0; wn = 0; iss_wn = 0; d = '0;
      model_reset();
      #12 clrn = 1;
      @(posedge clk); #1;
      test_reset();
      test_bypass();
      test_raw();
      test_saturation();
      test_flush_err();
      test_zero_reg();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
